rs_dispatch: RTL and testbench

Issue-side counterpart of the reservation station's decoder port. It accepts decoded instructions from the instruction queue and resolves source operands through the register-file tag lookup. It holds one instruction in a single-entry skid register and snoops the CDB while waiting, then drives the RS issue bundle (if_issue_rs, dest_rs, op_type_to_rs, tag/data for rs1/rs2, imm_to_rs, pc_to_rs) whenever the RS reports if_idle and the ROB has a free tag.

---
 rtl/rs_dispatch.sv | 145 ++++++++++++++
 tb/tb_rs_dispatch.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_dispatch.sv
// Decoder-port dispatcher for the reservation station: one-entry hold register
// that captures a decoded instruction, tracks its operands on the CDB and issues it.
module rs_dispatch #(
   parameter int TAG_W  = 4,
   parameter int DATA_W = 32,
   parameter int OP_W   = 6,
   parameter int IMM_W  = 32,
   parameter int ADDR_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              inst_valid,
   output logic              inst_ready,
   input  logic [OP_W-1:0]   inst_op,
   input  logic [REG_W-1:0]  inst_rd,
   input  logic [REG_W-1:0]  inst_rs1,
   input  logic [REG_W-1:0]  inst_rs2,
   input  logic [IMM_W-1:0]  inst_imm,
   input  logic [ADDR_W-1:0] inst_pc,
   output logic [REG_W-1:0]  reg_idx1,
   output logic [REG_W-1:0]  reg_idx2,
   input  logic [TAG_W-1:0]  reg_tag1,
   input  logic [TAG_W-1:0]  reg_tag2,
   input  logic [DATA_W-1:0] reg_data1,
   input  logic [DATA_W-1:0] reg_data2,
   output logic              rename_en,
   output logic [REG_W-1:0]  rename_rd,
   output logic [TAG_W-1:0]  rename_tag,
   input  logic              rob_idle,
   input  logic [TAG_W-1:0]  rob_free_tag,
   output logic              rob_alloc,
   input  logic              if_idle,
   output logic              if_issue_rs,
   output logic [TAG_W-1:0]  dest_rs,
   output logic [OP_W-1:0]   op_type_to_rs,
   output logic [TAG_W-1:0]  tag_rs1_to_rs,
   output logic [TAG_W-1:0]  tag_rs2_to_rs,
   output logic [DATA_W-1:0] data_rs1_to_rs,
   output logic [DATA_W-1:0] data_rs2_to_rs,
   output logic [IMM_W-1:0]  imm_to_rs,
   output logic [ADDR_W-1:0] pc_to_rs,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [DATA_W-1:0] cdb_data,
   input  logic              flush,
   output logic [31:0]       issued_count
);

   typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
   } opnd_t;

   // Tag 0 means the value is already present and must never be captured.
   function automatic opnd_t snoop(input opnd_t o, input logic cv,
                                   input logic [TAG_W-1:0] ct, input logic [DATA_W-1:0] cd);
      opnd_t r;
      r = o;
      if (cv && (o.tag != '0) && (o.tag == ct)) begin
         r.tag  = '0;
         r.data = cd;
      end
      return r;
   endfunction

   state_t            state, state_nxt;
   logic              fire, accept;
   logic [OP_W-1:0]   op_p0;
   logic [REG_W-1:0]  rd_p0;
   logic [IMM_W-1:0]  imm_p0;
   logic [ADDR_W-1:0] pc_p0;
   opnd_t             src1_p0, src2_p0;
   opnd_t             src1_fwd, src2_fwd;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= EMPTY;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      fire       = 1'b0;
      inst_ready = 1'b0;
      if (rst && rdy && !flush) begin
         fire       = (state == HOLD) && if_idle && rob_idle;
         inst_ready = (state == EMPTY) || fire;
      end
      accept = inst_valid && inst_ready;
      if (flush)       state_nxt = EMPTY;
      else if (accept) state_nxt = HOLD;
      else if (fire)   state_nxt = EMPTY;
   end

   // Stage p0: hold register, filled on accept and snooping the CDB while waiting
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_p0   <= '0;
         rd_p0   <= '0;
         imm_p0  <= '0;
         pc_p0   <= '0;
         src1_p0 <= '0;
         src2_p0 <= '0;
      end else if (accept) begin
         op_p0   <= inst_op;
         rd_p0   <= inst_rd;
         imm_p0  <= inst_imm;
         pc_p0   <= inst_pc;
         src1_p0 <= snoop({reg_tag1, reg_data1}, cdb_valid, cdb_tag, cdb_data);
         src2_p0 <= snoop({reg_tag2, reg_data2}, cdb_valid, cdb_tag, cdb_data);
      end else if (rdy && !flush && (state == HOLD)) begin
         src1_p0 <= snoop(src1_p0, cdb_valid, cdb_tag, cdb_data);
         src2_p0 <= snoop(src2_p0, cdb_valid, cdb_tag, cdb_data);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)      issued_count <= '0;
      else if (fire) issued_count <= issued_count + 32'd1;
   end

   assign src1_fwd = snoop(src1_p0, cdb_valid, cdb_tag, cdb_data);
   assign src2_fwd = snoop(src2_p0, cdb_valid, cdb_tag, cdb_data);

   assign if_issue_rs    = fire;
   assign rob_alloc      = fire;
   assign rename_en      = fire && (rd_p0 != '0);
   assign rename_rd      = rd_p0;
   // Pass-through fields are forced to zero while reset is held.
   assign rename_tag     = rst ? rob_free_tag : '0;
   assign dest_rs        = rst ? rob_free_tag : '0;
   assign reg_idx1       = rst ? inst_rs1 : '0;
   assign reg_idx2       = rst ? inst_rs2 : '0;
   assign op_type_to_rs  = op_p0;
   assign tag_rs1_to_rs  = src1_fwd.tag;
   assign data_rs1_to_rs = src1_fwd.data;
   assign tag_rs2_to_rs  = src2_fwd.tag;
   assign data_rs2_to_rs = src2_fwd.data;
   assign imm_to_rs      = imm_p0;
   assign pc_to_rs       = pc_p0;

endmodule

// File: tb/tb_rs_dispatch.sv
// Bench for rs_dispatch: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_rs_dispatch;

   logic        clk, rst, rdy;
   logic        inst_valid, inst_ready;
   logic [5:0]  inst_op;
   logic [4:0]  inst_rd, inst_rs1, inst_rs2;
   logic [31:0] inst_imm, inst_pc;
   logic [4:0]  reg_idx1, reg_idx2;
   logic [3:0]  reg_tag1, reg_tag2;
   logic [31:0] reg_data1, reg_data2;
   logic        rename_en;
   logic [4:0]  rename_rd;
   logic [3:0]  rename_tag;
   logic        rob_idle, rob_alloc, if_idle, if_issue_rs;
   logic [3:0]  rob_free_tag, dest_rs, tag_rs1_to_rs, tag_rs2_to_rs;
   logic [5:0]  op_type_to_rs;
   logic [31:0] data_rs1_to_rs, data_rs2_to_rs, imm_to_rs, pc_to_rs;
   logic        cdb_valid;
   logic [3:0]  cdb_tag;
   logic [31:0] cdb_data;
   logic        flush;
   logic [31:0] issued_count;

   int checks = 0;
   int errors = 0;

   rs_dispatch dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_op(inst_op),
      .inst_rd(inst_rd), .inst_rs1(inst_rs1), .inst_rs2(inst_rs2),
      .inst_imm(inst_imm), .inst_pc(inst_pc),
      .reg_idx1(reg_idx1), .reg_idx2(reg_idx2),
      .reg_tag1(reg_tag1), .reg_tag2(reg_tag2),
      .reg_data1(reg_data1), .reg_data2(reg_data2),
      .rename_en(rename_en), .rename_rd(rename_rd), .rename_tag(rename_tag),
      .rob_idle(rob_idle), .rob_free_tag(rob_free_tag), .rob_alloc(rob_alloc),
      .if_idle(if_idle), .if_issue_rs(if_issue_rs), .dest_rs(dest_rs),
      .op_type_to_rs(op_type_to_rs),
      .tag_rs1_to_rs(tag_rs1_to_rs), .tag_rs2_to_rs(tag_rs2_to_rs),
      .data_rs1_to_rs(data_rs1_to_rs), .data_rs2_to_rs(data_rs2_to_rs),
      .imm_to_rs(imm_to_rs), .pc_to_rs(pc_to_rs),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .flush(flush), .issued_count(issued_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic set_default();
      inst_valid = 0; inst_op = 6'h13; inst_rd = 5'd1; inst_rs1 = 5'd1; inst_rs2 = 5'd2;
      reg_tag1 = 0; reg_data1 = 32'd5; reg_tag2 = 0; reg_data2 = 32'h77;
      inst_imm = 32'd7; inst_pc = 32'h100; if_idle = 1; rob_idle = 1; rob_free_tag = 4'd3;
      cdb_valid = 0; cdb_tag = 0; cdb_data = 0; flush = 0; rdy = 1;
   endtask

   typedef struct {
      logic        iv;
      logic [3:0]  tg1, tg2;
      logic        idle, cv;
      logic [3:0]  ctag;
      logic [31:0] cdata;
      logic        e_ready, e_issue;
      logic [3:0]  e_t1;
      logic [31:0] e_d1;
      logic [3:0]  e_t2;
      logic [31:0] e_d2;
      logic [31:0] e_cnt;
   } vec_t;

   function automatic vec_t mk(logic iv, logic [3:0] tg1, logic [3:0] tg2, logic idle,
                               logic cv, logic [3:0] ctag, logic [31:0] cdata,
                               logic er, logic ei, logic [3:0] et1, logic [31:0] ed1,
                               logic [3:0] et2, logic [31:0] ed2, logic [31:0] ecnt);
      vec_t v;
      v.iv = iv; v.tg1 = tg1; v.tg2 = tg2; v.idle = idle; v.cv = cv; v.ctag = ctag;
      v.cdata = cdata; v.e_ready = er; v.e_issue = ei; v.e_t1 = et1; v.e_d1 = ed1;
      v.e_t2 = et2; v.e_d2 = ed2; v.e_cnt = ecnt;
      return v;
   endfunction

   // Reference model: the dispatcher is a queue holding at most one instruction.
   typedef struct {
      logic [5:0]  op;
      logic [4:0]  rd;
      logic [3:0]  t1, t2;
      logic [31:0] d1, d2, imm, pc;
   } inst_t;

   inst_t       held[$];
   logic [31:0] m_cnt;

   function automatic logic [35:0] fwd(input logic [3:0] t, input logic [31:0] d,
                                       input logic cv, input logic [3:0] ct, input logic [31:0] cd);
      if (cv && t != 0 && t == ct) return {4'h0, cd};
      return {t, d};
   endfunction

   vec_t vt[11];

   initial begin
      logic        have, e_fire, e_ready, acc;
      logic [35:0] o1, o2;
      inst_t       h, n;

      set_default();
      rst = 0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_issue", if_issue_rs, 0);
      chk("rst_ready", inst_ready, 0);
      chk("rst_alloc", rob_alloc, 0);
      chk("rst_rename", rename_en, 0);
      chk("rst_dest", dest_rs, 0);
      chk("rst_pc", pc_to_rs, 0);
      chk("rst_cnt", issued_count, 0);
      @(negedge clk);
      rst = 1;

      vt[0]  = mk(1, 0, 0, 1, 0, 0, 0,        1, 0, 0, 0, 0, 0,        0);
      vt[1]  = mk(0, 0, 0, 1, 0, 0, 0,        1, 1, 0, 5, 0, 32'h77,   0);
      vt[2]  = mk(1, 0, 5, 0, 0, 0, 0,        1, 0, 0, 0, 0, 0,        1);
      vt[3]  = mk(1, 0, 5, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0,        1);
      vt[4]  = mk(1, 0, 5, 0, 1, 5, 32'hDEAD, 0, 0, 0, 0, 0, 0,        1);
      vt[5]  = mk(1, 0, 5, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0,        1);
      vt[6]  = mk(1, 0, 5, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0,        1);
      vt[7]  = mk(0, 0, 0, 1, 0, 0, 0,        1, 1, 0, 5, 0, 32'hDEAD, 1);
      vt[8]  = mk(1, 2, 0, 0, 0, 0, 0,        1, 0, 0, 0, 0, 0,        2);
      vt[9]  = mk(0, 0, 0, 1, 1, 2, 9,        1, 1, 0, 9, 0, 32'h77,   2);
      vt[10] = mk(0, 0, 0, 1, 0, 0, 0,        1, 0, 0, 0, 0, 0,        3);

      for (int i = 0; i < 11; i++) begin
         set_default();
         inst_valid = vt[i].iv; reg_tag1 = vt[i].tg1; reg_tag2 = vt[i].tg2;
         if_idle = vt[i].idle; cdb_valid = vt[i].cv; cdb_tag = vt[i].ctag; cdb_data = vt[i].cdata;
         #1;
         chk($sformatf("v%0d_ready", i), inst_ready, vt[i].e_ready);
         chk($sformatf("v%0d_issue", i), if_issue_rs, vt[i].e_issue);
         chk($sformatf("v%0d_cnt", i), issued_count, vt[i].e_cnt);
         if (vt[i].e_issue) begin
            chk($sformatf("v%0d_dest", i), dest_rs, 3);
            chk($sformatf("v%0d_t1", i), tag_rs1_to_rs, vt[i].e_t1);
            chk($sformatf("v%0d_d1", i), data_rs1_to_rs, vt[i].e_d1);
            chk($sformatf("v%0d_t2", i), tag_rs2_to_rs, vt[i].e_t2);
            chk($sformatf("v%0d_d2", i), data_rs2_to_rs, vt[i].e_d2);
            chk($sformatf("v%0d_imm", i), imm_to_rs, 7);
            chk($sformatf("v%0d_pc", i), pc_to_rs, 32'h100);
            chk($sformatf("v%0d_ren", i), rename_en, 1);
            chk($sformatf("v%0d_rrd", i), rename_rd, 1);
         end
         @(negedge clk);
      end

      // Back-to-back: eight instructions, one issue per cycle after the first accept.
      for (int i = 0; i < 9; i++) begin
         set_default();
         inst_valid = (i < 8);
         inst_pc = 32'h200 + 32'(4 * i);
         #1;
         chk("b2b_ready", inst_ready, 1);
         if (i > 0) begin
            chk("b2b_issue", if_issue_rs, 1);
            chk("b2b_pc", pc_to_rs, 32'h200 + 32'(4 * (i - 1)));
         end
         @(negedge clk);
      end
      set_default();
      #1;
      chk("b2b_idle", if_issue_rs, 0);
      chk("b2b_cnt", issued_count, 11);

      // Flush while holding with the RS free.
      @(negedge clk);
      set_default(); inst_valid = 1; if_idle = 0; inst_pc = 32'h300;
      @(negedge clk);
      set_default(); flush = 1; inst_valid = 1;
      #1;
      chk("flush_issue", if_issue_rs, 0);
      chk("flush_ready", inst_ready, 0);
      @(negedge clk);
      set_default();
      #1;
      chk("flush_empty", if_issue_rs, 0);
      chk("flush_cnt", issued_count, 11);

      // rd = x0 issues but is never renamed.
      @(negedge clk);
      set_default(); inst_valid = 1; inst_rd = 0; if_idle = 0;
      @(negedge clk);
      set_default();
      #1;
      chk("x0_issue", if_issue_rs, 1);
      chk("x0_rename", rename_en, 0);
      @(negedge clk);
      set_default();
      #1;
      chk("x0_cnt", issued_count, 12);

      // Reset pulsed while an instruction is held.
      @(negedge clk);
      set_default(); inst_valid = 1; if_idle = 0; inst_pc = 32'h400;
      @(negedge clk);
      set_default(); if_idle = 0;
      #1;
      chk("mr_stall", if_issue_rs, 0);
      #1;
      rst = 0; if_idle = 1;
      #1;
      chk("mr_issue", if_issue_rs, 0);
      chk("mr_ready", inst_ready, 0);
      chk("mr_dest", dest_rs, 0);
      chk("mr_pc", pc_to_rs, 0);
      chk("mr_rename", rename_en, 0);
      chk("mr_cnt", issued_count, 0);
      @(negedge clk);
      rst = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("mr_after_issue", if_issue_rs, 0);
         chk("mr_after_ready", inst_ready, 1);
         @(negedge clk);
      end

      // Randomized traffic against the reference model (DUT is empty, count 0).
      held.delete();
      m_cnt = 0;
      for (int c = 0; c < 600; c++) begin
         inst_valid = ($urandom_range(0, 3) != 0);
         inst_op = 6'($urandom); inst_rd = 5'($urandom_range(0, 3));
         inst_rs1 = 5'($urandom); inst_rs2 = 5'($urandom);
         reg_tag1 = 4'($urandom_range(0, 3)); reg_tag2 = 4'($urandom_range(0, 3));
         reg_data1 = $urandom; reg_data2 = $urandom;
         inst_imm = $urandom; inst_pc = $urandom;
         if_idle = ($urandom_range(0, 3) != 0); rob_idle = ($urandom_range(0, 3) != 0);
         rob_free_tag = 4'($urandom_range(1, 15));
         cdb_valid = $urandom_range(0, 1); cdb_tag = 4'($urandom_range(0, 3)); cdb_data = $urandom;
         flush = ($urandom_range(0, 19) == 0); rdy = ($urandom_range(0, 9) != 0);
         #1;
         have    = (held.size() != 0);
         e_fire  = have && if_idle && rob_idle && rdy && !flush;
         e_ready = rdy && !flush && (!have || e_fire);
         acc     = inst_valid && e_ready;
         chk("r_ready", inst_ready, e_ready);
         chk("r_issue", if_issue_rs, e_fire);
         chk("r_alloc", rob_alloc, e_fire);
         chk("r_cnt", issued_count, m_cnt);
         chk("r_idx1", reg_idx1, inst_rs1);
         chk("r_idx2", reg_idx2, inst_rs2);
         chk("r_ren", rename_en, e_fire && held[0].rd != 0);
         if (e_fire) begin
            h  = held[0];
            o1 = fwd(h.t1, h.d1, cdb_valid, cdb_tag, cdb_data);
            o2 = fwd(h.t2, h.d2, cdb_valid, cdb_tag, cdb_data);
            chk("r_dest", dest_rs, rob_free_tag);
            chk("r_rtag", rename_tag, rob_free_tag);
            chk("r_rrd", rename_rd, h.rd);
            chk("r_op", op_type_to_rs, h.op);
            chk("r_t1", tag_rs1_to_rs, o1[35:32]);
            chk("r_d1", data_rs1_to_rs, o1[31:0]);
            chk("r_t2", tag_rs2_to_rs, o2[35:32]);
            chk("r_d2", data_rs2_to_rs, o2[31:0]);
            chk("r_imm", imm_to_rs, h.imm);
            chk("r_pc", pc_to_rs, h.pc);
         end
         @(posedge clk);
         if (flush) held.delete();
         else if (rdy) begin
            if (e_fire) begin
               void'(held.pop_front());
               m_cnt++;
            end else if (have) begin
               h = held[0];
               {h.t1, h.d1} = fwd(h.t1, h.d1, cdb_valid, cdb_tag, cdb_data);
               {h.t2, h.d2} = fwd(h.t2, h.d2, cdb_valid, cdb_tag, cdb_data);
               held[0] = h;
            end
            if (acc) begin
               n.op = inst_op; n.rd = inst_rd; n.imm = inst_imm; n.pc = inst_pc;
               {n.t1, n.d1} = fwd(reg_tag1, reg_data1, cdb_valid, cdb_tag, cdb_data);
               {n.t2, n.d2} = fwd(reg_tag2, reg_data2, cdb_valid, cdb_tag, cdb_data);
               held.push_back(n);
            end
         end
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
